// File: rtl/retirer.sv
// -----------------------------------------------------------------------------
// retirer -- writeback stage of the five-stage pipeline.
//
// Accepts one completed instruction per cycle from the memory accessor,
// extracts and sign/zero-extends load data, and drives the register-file
// write port one cycle after the transfer. A misaligned load halts the core
// (sticky trap, only reset recovers). Also keeps 64-bit cycle and
// retired-instruction counters.
//
// Handshake: a transfer happens on a rising edge where accessor_valid and
// writeback_ready are both 1. writeback_ready depends only on state (1 in
// RUN, 0 in HALT), never on accessor_valid. Accessor inputs are sampled only
// on a transfer edge.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   accessor_valid        accessor presents a completed instruction
//   writeback_ready       retirer can accept this cycle
//   accessor_rd           destination register index
//   accessor_rd_data      ALU/CSR result for non-load instructions
//   accessor_is_l*        load type flags (priority lw > lh > lhu > lb > lbu)
//   accessor_mem_offset   low two bits of the load address
//   accessor_mem_rdata    aligned memory word returned for the load
//   wen/waddr/wdata       register-file write port (registered)
//   fwd_valid/rd/data     decoder bypass, identical to the write port
//   retire_valid          one pulse per retired instruction (including x0)
//   trap                  sticky misaligned-load halt
//   cycle_count           cycles since reset
//   retire_count          instructions retired since reset
//   dbg_state             current FSM state (0 = RUN, 1 = HALT)
// -----------------------------------------------------------------------------
module retirer (
  input  logic        clk,
  input  logic        reset,
  input  logic        accessor_valid,
  output logic        writeback_ready,
  input  logic [4:0]  accessor_rd,
  input  logic [31:0] accessor_rd_data,
  input  logic        accessor_is_lb,
  input  logic        accessor_is_lbu,
  input  logic        accessor_is_lh,
  input  logic        accessor_is_lhu,
  input  logic        accessor_is_lw,
  input  logic [1:0]  accessor_mem_offset,
  input  logic [31:0] accessor_mem_rdata,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        retire_valid,
  output logic        trap,
  output logic [63:0] cycle_count,
  output logic [63:0] retire_count,
  output logic        dbg_state
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        retire_valid_q, retire_valid_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] retire_q, retire_d;

  logic        xfer;
  logic        misaligned;
  logic [31:0] result;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = accessor_mem_rdata[8*accessor_mem_offset +: 8];
  assign sel_half = accessor_mem_rdata[16*accessor_mem_offset[1] +: 16];

  // Load decode: the highest-priority flag alone decides both the result and
  // whether the access is misaligned.
  always_comb begin
    result     = accessor_rd_data;
    misaligned = 1'b0;
    if (accessor_is_lw) begin
      result     = accessor_mem_rdata;
      misaligned = (accessor_mem_offset != 2'd0);
    end else if (accessor_is_lh) begin
      result     = {{16{sel_half[15]}}, sel_half};
      misaligned = accessor_mem_offset[0];
    end else if (accessor_is_lhu) begin
      result     = {16'd0, sel_half};
      misaligned = accessor_mem_offset[0];
    end else if (accessor_is_lb) begin
      result     = {{24{sel_byte[7]}}, sel_byte};
    end else if (accessor_is_lbu) begin
      result     = {24'd0, sel_byte};
    end
  end

  assign writeback_ready = (state_q == RUN);
  assign xfer            = accessor_valid && writeback_ready;

  always_comb begin
    state_d        = state_q;
    wen_d          = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    retire_valid_d = 1'b0;
    cycle_d        = cycle_q + 64'd1;
    retire_d       = retire_q;
    if (xfer) begin
      if (misaligned) begin
        state_d = HALT;
      end else begin
        // rd = x0 still retires and updates waddr/wdata, but never writes.
        wen_d          = (accessor_rd != 5'd0);
        waddr_d        = accessor_rd;
        wdata_d        = result;
        retire_valid_d = 1'b1;
        retire_d       = retire_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wen_q          <= 1'b0;
      waddr_q        <= 5'd0;
      wdata_q        <= 32'd0;
      retire_valid_q <= 1'b0;
      cycle_q        <= 64'd0;
      retire_q       <= 64'd0;
    end else begin
      state_q        <= state_d;
      wen_q          <= wen_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      retire_valid_q <= retire_valid_d;
      cycle_q        <= cycle_d;
      retire_q       <= retire_d;
    end
  end

  assign wen          = wen_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign fwd_valid    = wen_q;
  assign fwd_rd       = waddr_q;
  assign fwd_data     = wdata_q;
  assign retire_valid = retire_valid_q;
  assign trap         = (state_q == HALT);
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/retirer.md
# retirer

Final (writeback) stage of the five-stage pipeline, directly downstream of the memory accessor. Accepts one completed instruction per cycle over a valid/ready handshake, extracts and sign/zero-extends load data, and drives the register-file write port. Detects misaligned loads (halting with `trap`), exposes a same-cycle bypass to the decoder, and maintains the 64-bit cycle and retired-instruction counters.

## Interface
Parameters:
- `RESET_PC` — n/a; block has no parameters. All widths are fixed: XLEN = 32, register index = 5.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, all state updates on rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `accessor_valid` in 1 — accessor presents a completed instruction.
- `writeback_ready` out 1 — retirer can accept this cycle.
- `accessor_rd` in 5 — destination register.
- `accessor_rd_data` in 32 — ALU/CSR result for non-load instructions.
- `accessor_is_lb`, `accessor_is_lbu`, `accessor_is_lh`, `accessor_is_lhu`, `accessor_is_lw` in 1 each — load type; all zero for non-loads.
- `accessor_mem_offset` in 2 — low two bits of the load address.
- `accessor_mem_rdata` in 32 — aligned memory word returned for the load.
- `wen` out 1 — register-file write enable.
- `waddr` out 5 — register-file write index.
- `wdata` out 32 — register-file write data.
- `fwd_valid` out 1 — bypass valid (equals `wen`).
- `fwd_rd` out 5, `fwd_data` out 32 — bypass index/data (equal `waddr`/`wdata`).
- `retire_valid` out 1 — one pulse per retired instruction, including rd = x0.
- `trap` out 1 — sticky misaligned-load halt.
- `cycle_count` out 64 — cycles since reset.
- `retire_count` out 64 — instructions retired since reset.

## Operation
- States: RUN, HALT. Reset → RUN.
- `writeback_ready` = 1 in RUN, 0 in HALT. Combinational from state only; never depends on `accessor_valid`.
- Transfer occurs on an edge where `accessor_valid && writeback_ready`. All accessor inputs are sampled on that edge only.
- Load type priority if several flags are set: lw > lh > lhu > lb > lbu.
- Result selection:
  - lb: byte `rdata[8*off +: 8]` sign-extended.
  - lbu: the same byte, zero-extended.
  - lh: halfword `rdata[16*off[1] +: 16]` sign-extended.
  - lhu: the same halfword, zero-extended.
  - lw: `rdata`.
  - No load flag: `accessor_rd_data`.
- Misaligned load: lh/lhu with off[0] = 1, or lw with off ≠ 0.
  - On transfer: no write, no `retire_valid`, no `retire_count` increment.
  - `trap` rises and state → HALT.
  - Only `reset` leaves HALT.
- Aligned transfer:
  - Next cycle: `retire_valid` = 1 and `retire_count` += 1.
  - `wen` = 1 only if rd ≠ 0, with `waddr` = rd and `wdata` = result.
  - If rd = 0: `wen` = 0, but `waddr`/`wdata` still update.
- No transfer: `wen`, `retire_valid` = 0 next cycle. `waddr`/`wdata` hold.
- `cycle_count` increments every cycle not in reset, including HALT. Both counters wrap modulo 2^64 silently.

## Timing
- Reset values: state RUN, `writeback_ready` 1, `wen` 0, `waddr` 0, `wdata` 0, `fwd_*` mirror these, `retire_valid` 0, `trap` 0, `cycle_count` 0, `retire_count` 0.
- Latency is one cycle: transfer at edge N → `wen`/`retire_valid` high in cycle N+1 → regfile writes at edge N+1.
- Throughput: one instruction per cycle, back-to-back, with no bubbles in RUN.
- `retire_count` reflects the instruction in the same cycle its `retire_valid` is high.
- `trap` is visible in the cycle after the offending transfer; `writeback_ready` drops in that same cycle.
- Reset asserted mid-stream: at that edge all state returns to reset values. A transfer coincident with reset is discarded (no write in the following cycle).
- Decoder bypass contract: `fwd_*` is registered and valid in the same cycle as the regfile write. The regfile is write-before-read transparent only via this bypass.

## Test plan
- **ALU result:** rd = 5, rd_data = 0xDEADBEEF, no load flags, valid 1 cycle → next cycle `wen` = 1, `waddr` = 5, `wdata` = 0xDEADBEEF, `retire_count` = 1.
- **Byte loads:** lb, off = 2, rdata = 0x0080_0000, rd = 3 → `wdata` = 0xFFFFFF80. Same with lbu → 0x00000080.
- **Halfword loads:** lhu, off = 2, rdata = 0x8001_1234 → `wdata` = 0x00008001. lh → 0xFFFF8001.
- **x0 plus back-to-back:** 4 consecutive transfers with rd = 0,1,0,2 → `retire_valid` high 4 consecutive cycles, `wen` pattern 0,1,0,1, `retire_count` = 4.
- **Misaligned lw:** off = 1, rd = 7 → no write, `trap` = 1, `writeback_ready` = 0; further valids are ignored and `retire_count` is unchanged; `cycle_count` keeps incrementing. Assert `reset` → `trap` = 0, ready = 1.
- **Reset mid-stream:** `reset` coincident with a valid transfer → `wen` = 0 the next cycle and both counters = 0.
